// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM pipeline stage.
// The MEM/WB bundle is one flat vector laid out {wb, imm, alu, mem}, LSB first.
package mem_pkg;

    localparam int unsigned MEM_W_DEF    = 16;
    localparam int unsigned MEM_AW_DEF   = 11;
    localparam int unsigned MEM_WB_W_DEF = 3;
    localparam int unsigned MEM_TMO_DEF  = 255;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    // MEM/WB bundle field offsets for a datapath of width w
    function automatic int unsigned memwb_mem_lsb(input int unsigned w);
        return 0 * w;
    endfunction

    function automatic int unsigned memwb_alu_lsb(input int unsigned w);
        return w;
    endfunction

    function automatic int unsigned memwb_imm_lsb(input int unsigned w);
        return 2 * w;
    endfunction

    function automatic int unsigned memwb_wb_lsb(input int unsigned w);
        return 3 * w;
    endfunction

    function automatic int unsigned memwb_bits(input int unsigned w, input int unsigned wb_w);
        return 3 * w + wb_w;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus watchdog: cleared on load, counts enabled cycles, flags the last allowed
// wait cycle. Saturates instead of wrapping.
module mem_timeout_ctr #(
    parameter int unsigned TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(TMO))) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt holds the number of completed wait cycles, so TMO-1 marks the TMO-th one
    assign expire_c = en && (cnt == CW'(TMO - 1));

endmodule

// File: rtl/mem_stage_pipe.sv
// Registered MEM stage: operand muxing, req/ack memory handshake with upstream
// stall, bus watchdog with sticky error, and the MEM/WB output register.
module mem_stage_pipe
    import mem_pkg::*;
#(
    parameter int unsigned W    = MEM_W_DEF,
    parameter int unsigned AW   = MEM_AW_DEF,
    parameter int unsigned WB_W = MEM_WB_W_DEF,
    parameter int unsigned TMO  = MEM_TMO_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [WB_W-1:0] wb_in,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            addr_sel,
    input  logic            data_sel,
    input  logic [W-1:0]    rsrc,
    input  logic [W-1:0]    rdst,
    input  logic [W-1:0]    alu,
    input  logic [W-1:0]    imm,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [W-1:0]    mem_wdata,
    input  logic            mem_ack,
    input  logic [W-1:0]    mem_rdata,
    output logic            out_valid,
    output logic [WB_W-1:0] out_wb,
    output logic [W-1:0]    out_imm,
    output logic [W-1:0]    out_alu,
    output logic [W-1:0]    out_mem,
    output logic            bus_err
);

    localparam int unsigned BW      = memwb_bits(W, WB_W);
    localparam int unsigned MEM_LSB = memwb_mem_lsb(W);
    localparam int unsigned ALU_LSB = memwb_alu_lsb(W);
    localparam int unsigned IMM_LSB = memwb_imm_lsb(W);
    localparam int unsigned WB_LSB  = memwb_wb_lsb(W);

    mem_state_e state;
    mem_state_e state_nxt;

    logic            mem_op_c;
    logic [AW-1:0]   sel_addr_c;
    logic [W-1:0]    sel_wdata_c;
    logic            ctr_load_c;
    logic            ctr_en_c;
    logic            tmo_c;

    logic            lat_we;
    logic [AW-1:0]   lat_addr;
    logic [W-1:0]    lat_wdata;
    logic [WB_W-1:0] lat_wb;
    logic [W-1:0]    lat_imm;
    logic [W-1:0]    lat_alu;
    logic [BW-1:0]   memwb_q;

    assign mem_op_c    = mem_read | mem_write;
    assign sel_addr_c  = addr_sel ? rdst[AW-1:0] : rsrc[AW-1:0];
    assign sel_wdata_c = data_sel ? rdst : rsrc;

    mem_timeout_ctr #(
        .TMO (TMO)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load_c),
        .en       (ctr_en_c),
        .expire_c (tmo_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && mem_op_c) state_nxt = ACCESS;
            ACCESS:  if (mem_ack || tmo_c)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; gated by reset so the request drops the moment rst falls
    always_comb begin
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ctr_load_c = 1'b0;
        ctr_en_c   = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (in_valid && mem_op_c) begin
                        stall      = 1'b1;
                        mem_req    = 1'b1;
                        mem_we     = mem_write;
                        mem_addr   = sel_addr_c;
                        mem_wdata  = sel_wdata_c;
                        ctr_load_c = 1'b1;
                    end
                end
                ACCESS: begin
                    mem_req   = 1'b1;
                    mem_we    = lat_we;
                    mem_addr  = lat_addr;
                    mem_wdata = lat_wdata;
                    stall     = !mem_ack;
                    ctr_en_c  = !mem_ack;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            bus_err   <= 1'b0;
            memwb_q   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wb    <= '0;
            lat_imm   <= '0;
            lat_alu   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && mem_op_c) begin
                        out_valid <= 1'b0;
                        lat_we    <= mem_write;
                        lat_addr  <= sel_addr_c;
                        lat_wdata <= sel_wdata_c;
                        lat_wb    <= wb_in;
                        lat_imm   <= imm;
                        lat_alu   <= alu;
                    end else if (in_valid) begin
                        out_valid <= 1'b1;
                        memwb_q   <= {wb_in, imm, alu, {W{1'b0}}};
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        out_valid <= 1'b1;
                        memwb_q   <= {lat_wb, lat_imm, lat_alu, lat_we ? {W{1'b0}} : mem_rdata};
                    end else if (tmo_c) begin
                        out_valid <= 1'b1;
                        bus_err   <= 1'b1;
                        memwb_q   <= {lat_wb, lat_imm, lat_alu, {W{1'b0}}};
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

    assign out_mem = memwb_q[MEM_LSB +: W];
    assign out_alu = memwb_q[ALU_LSB +: W];
    assign out_imm = memwb_q[IMM_LSB +: W];
    assign out_wb  = memwb_q[WB_LSB  +: WB_W];

endmodule
